fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Two-requester write arbiter that shares one byte-wide transmit FIFO between independent producers, e.g. a command responder and a status reporter, in front of the UART transmitter. Requests are granted round-robin. A grant is held for a burst that ends on the requester's `last` flag, on a burst cap, or when the requester withdraws. The block drives the FIFO write port directly and honours its `full` flag, so no word is ever dropped.

## Interface
- `B`, default 8: data word width; must match the FIFO word width.
- `MAX_BURST`, default 4: maximum words accepted per grant; range 1..255.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0`  in  1  requester 0 has a word on `data0`.
- `data0`  in  B  requester 0 word.
- `last0`  in  1  current `data0` word is the final word of its burst.
- `ack0`  out  1  `data0` was written to the FIFO this cycle.
- `req1`, `data1`, `last1`, `ack1`: same meanings for requester 1.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_wr`  out  1  FIFO write strobe.
- `fifo_w_data`  out  B  FIFO write data.
- `grant`  out  2  one-hot current owner; bit 0 is requester 0.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- **States:** IDLE, GRANT0, GRANT1.
- **Registers:** state, round-robin pointer `prio` (1 bit), burst counter `cnt`.
  - `cnt` is `$clog2(MAX_BURST+1)` bits wide and saturates by construction.
- **IDLE:**
  - If only one requester asserts `req`, it is granted.
  - If both assert `req`, requester `prio` is granted.
  - Transition to GRANTx on the next edge; `cnt` is cleared to 0.
  - Outputs in IDLE: `fifo_wr`=0, all acks 0.
- **GRANTx (combinational):**
  - `fifo_wr` = `reqx & ~fifo_full`.
  - `fifo_w_data` = `datax`.
  - `ackx` = `fifo_wr`.
  - The other ack is 0.
  - In IDLE, `fifo_w_data` = `data0` (don't-care, but deterministic).
- **Accepted word:** `fifo_wr`=1. `cnt` increments by 1.
- **Release conditions in GRANTx** (any one of these moves the state to IDLE on the next edge):
  - an accepted word with `lastx`=1;
  - an accepted word making `cnt`+1 == `MAX_BURST`;
  - `reqx`=0 (withdrawal; no word is written that cycle).
- **On release,** `prio` is set to the other requester, whether or not that requester is asserting `req`.
- **FIFO full during GRANTx:**
  - `fifo_wr`=0 and `ackx`=0.
  - `cnt`, state and `prio` hold.
  - Grant is retained indefinitely until space frees or the requester withdraws.
- **Requester contract:**
  - `datax`/`lastx` must be held stable while `reqx`=1 and `ackx`=0.
  - The next word is presented in the cycle after an ack.
- **Reset**, including in the middle of a burst:
  - Next state IDLE, `prio`=0, `cnt`=0.
  - Outputs `fifo_wr`=0, `ack0`=`ack1`=0, `grant`=2'b00, `busy`=0.
  - Any partial burst is abandoned; words already written stay in the FIFO.

## Timing
- **Grant latency:** `req` sampled in IDLE → `grant` and the first possible `ack` in the following cycle.
- **Throughput within a grant:** one word per cycle while `fifo_full`=0.
- **Release overhead:** one IDLE bubble cycle between consecutive grants, including the same requester re-granting.
- **Combinational paths:**
  - `fifo_wr`/`ack` depend combinationally on `req`, `fifo_full` and the registered state.
  - No combinational path from `fifo_full` to `grant`.
- **Registered outputs:** `grant` and `busy` are decoded from the registered state only.

## Structure
- **Shared package `uart_pkg`:**
  - state enum `ARB_IDLE`, `ARB_GRANT0`, `ARB_GRANT1` (2 bits);
  - default constants `FIFO_B`=8 and `ARB_MAX_BURST`=4.
- **Single module,** no sub-module.
  - The FIFO is instantiated alongside this block by the parent, not inside it.
  - Expected RTL size is about 150 lines: state register, counter, next-state/output `always @*`.

## Test plan
- **Single requester:** `req0`=1, bytes 0xA1, 0xA2, 0xA3 with `last0` on 0xA3, FIFO empty → `grant`=01 one cycle after `req0`. Three consecutive `ack0` pulses, FIFO receives A1, A2, A3. IDLE on the next cycle, `prio`=1.
- **Contention:** `req0` and `req1` rise in the same cycle after reset, both bursts 2 words (0x10, 0x11 / 0x20, 0x21). → Requester 0 is served first, one IDLE bubble, then requester 1. FIFO order is 10, 11, 20, 21.
- **Burst cap:** `MAX_BURST`=4, `req1` streams 6 words 0x30..0x35 with `last1` only on 0x35, `req0` idle. → Release after 0x33 and re-grant to requester 1 after the bubble. 0x34 and 0x35 are accepted in the second grant.
- **FIFO full stall:** `fifo_full` forced to 1 for 5 cycles while granted to requester 0 mid-burst → `ack0`=0 and `fifo_wr`=0 for exactly 5 cycles. `grant`=01 is held, `cnt` unchanged, and the burst resumes with no lost or duplicated byte.
- **Withdrawal:** `req1` drops after one accepted word, without `last1` → IDLE next cycle, `prio`=0, no further writes.
- **Reset mid-burst:** `reset`=1 for one cycle while `grant`=10 → the next cycle shows `grant`=00, `busy`=0, `fifo_wr`=0. With both requesting afterwards, requester 0 wins (`prio`=0).

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART transmit path. Holds the
//                write-arbiter state encoding and the default word width and
//                burst cap used by fifo_wr_arbiter and its interface.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Default transmit FIFO word width.
    localparam int FIFO_B        = 8;

    // Default maximum number of words accepted per arbiter grant.
    localparam int ARB_MAX_BURST = 4;

    // Write-arbiter state encoding.
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT0 = 2'd1,
        ARB_GRANT1 = 2'd2
    } arb_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arbiter_if
//  Description : Bundle of the two requester channels, the transmit FIFO
//                write port and the arbiter status outputs.
//                Ports carried:
//                  reqN/dataN/lastN  requester N word offer  (master -> slave)
//                  ackN              word N written to FIFO  (slave -> master)
//                  fifo_full         FIFO full flag          (master -> slave)
//                  fifo_wr/fifo_w_data  FIFO write port      (slave -> master)
//                  grant/busy        arbiter status          (slave -> master)
//                The arbiter uses the slave modport; the environment
//                (requesters plus FIFO) uses the master modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_wr_arbiter_if
    import uart_pkg::*;
#(
    parameter int B = FIFO_B
);
    logic         req0;
    logic [B-1:0] data0;
    logic         last0;
    logic         ack0;
    logic         req1;
    logic [B-1:0] data1;
    logic         last1;
    logic         ack1;
    logic         fifo_full;
    logic         fifo_wr;
    logic [B-1:0] fifo_w_data;
    logic [1:0]   grant;
    logic         busy;

    modport master (
        output req0, data0, last0,
        output req1, data1, last1,
        output fifo_full,
        input  ack0, ack1,
        input  fifo_wr, fifo_w_data,
        input  grant, busy
    );

    modport slave (
        input  req0, data0, last0,
        input  req1, data1, last1,
        input  fifo_full,
        output ack0, ack1,
        output fifo_wr, fifo_w_data,
        output grant, busy
    );

endinterface : fifo_wr_arbiter_if
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arbiter
//  Description : Round-robin write arbiter sharing one transmit FIFO between
//                two producers. A grant lasts until the owner flags its last
//                word, reaches MAX_BURST accepted words, or withdraws its
//                request. Writes are suppressed while the FIFO is full, so no
//                word is ever dropped.
//                Ports:
//                  clk    system clock, rising edge
//                  reset  synchronous active-high reset
//                  bus    fifo_wr_arbiter_if.slave (requesters, FIFO write
//                         port, grant/busy status)
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import uart_pkg::*;
#(
    parameter int B         = FIFO_B,
    parameter int MAX_BURST = ARB_MAX_BURST
) (
    input  logic             clk,
    input  logic             reset,
    fifo_wr_arbiter_if.slave bus
);

    localparam int                 c_CNT_W    = $clog2(MAX_BURST + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    // Count value at which the next accepted word closes the burst.
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MAX_BURST - 1);

    arb_state_e         r_state;
    logic               r_prio;
    logic [c_CNT_W-1:0] r_cnt;

    arb_state_e         w_state_nxt;
    logic               w_prio_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;

    logic               w_sel1;
    logic               w_req;
    logic               w_last;
    logic [B-1:0]       w_data;
    logic               w_wr;

    // Owner-side mux. Outside GRANT1 this selects requester 0, which also
    // gives the deterministic data0 on the write bus while idle.
    assign w_sel1 = (r_state == ARB_GRANT1);
    assign w_req  = w_sel1 ? bus.req1  : bus.req0;
    assign w_last = w_sel1 ? bus.last1 : bus.last0;
    assign w_data = w_sel1 ? bus.data1 : bus.data0;

    always_comb begin
        w_state_nxt = r_state;
        w_prio_nxt  = r_prio;
        w_cnt_nxt   = r_cnt;
        w_wr        = 1'b0;

        case (r_state)
            ARB_IDLE: begin
                w_cnt_nxt = '0;
                if (bus.req0 && (!bus.req1 || !r_prio)) begin
                    w_state_nxt = ARB_GRANT0;
                end else if (bus.req1) begin
                    w_state_nxt = ARB_GRANT1;
                end
            end

            ARB_GRANT0, ARB_GRANT1: begin
                if (!w_req) begin
                    // Withdrawal: nothing written, hand priority away.
                    w_state_nxt = ARB_IDLE;
                    w_prio_nxt  = ~w_sel1;
                end else if (!bus.fifo_full) begin
                    w_wr      = 1'b1;
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                    if (w_last || (r_cnt == c_CNT_LAST)) begin
                        w_state_nxt = ARB_IDLE;
                        w_prio_nxt  = ~w_sel1;
                    end
                end
                // FIFO full: state, count and priority all hold.
            end

            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ARB_IDLE;
            r_prio  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_prio  <= w_prio_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign bus.fifo_wr     = w_wr;
    assign bus.fifo_w_data = w_data;
    assign bus.ack0        = w_wr & ~w_sel1;
    assign bus.ack1        = w_wr &  w_sel1;

    // Status is decoded from the state register only, so fifo_full has no
    // combinational route to grant.
    assign bus.grant = {(r_state == ARB_GRANT1), (r_state == ARB_GRANT0)};
    assign bus.busy  = (r_state != ARB_IDLE);

endmodule : fifo_wr_arbiter
`default_nettype wire
